uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg.sv | 146 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.
// Flags parity/framing errors and line breaks as pulses that line up with o_rx_valid.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_serial,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MID_C  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DLAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] SLAST  = IW'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY_MODE != 0);
  localparam bit ODD_PAR = (PARITY_MODE == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH} state_t;

  state_t               state, state_nxt;
  logic                 sync1, rxs;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_bit, ferr_acc, any_one;
  logic                 cnt_clr, sample, load;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= i_rx_serial;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    sample    = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rxs) state_nxt = START;
      end
      START: if (cnt == MID_C) begin
        cnt_clr   = 1'b1;
        state_nxt = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == LAST_C) begin
        cnt_clr = 1'b1;
        sample  = 1'b1;
        if (idx == DLAST) state_nxt = HAS_PAR ? PARITY : STOP;
      end
      PARITY: if (cnt == LAST_C) begin
        cnt_clr   = 1'b1;
        sample    = 1'b1;
        state_nxt = STOP;
      end
      STOP: if (cnt == LAST_C) begin
        cnt_clr = 1'b1;
        sample  = 1'b1;
        if (idx == SLAST) begin
          load      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        cnt_clr   = 1'b1;
        state_nxt = rxs ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (rxs) state_nxt = IDLE;
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are loaded on the last stop sample so they are live during DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt          <= '0;
      idx          <= '0;
      data_sr      <= '0;
      par_bit      <= 1'b0;
      ferr_acc     <= 1'b0;
      any_one      <= 1'b0;
      o_rx_valid   <= 1'b0;
      o_rx_data    <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      cnt          <= cnt_clr ? '0 : cnt + 1'b1;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      if (state == IDLE) begin
        idx      <= '0;
        ferr_acc <= 1'b0;
        any_one  <= 1'b0;
      end
      if (sample) begin
        any_one <= any_one | rxs;
        idx     <= (state_nxt != state) ? '0 : idx + 1'b1;
        case (state)
          DATA:    data_sr <= {rxs, data_sr[DATA_BITS-1:1]};
          PARITY:  par_bit <= rxs;
          STOP:    if (!rxs) ferr_acc <= 1'b1;
          default: ;
        endcase
      end
      if (load) begin
        o_rx_valid   <= 1'b1;
        o_rx_data    <= data_sr;
        o_parity_err <= HAS_PAR && ((^data_sr ^ par_bit) != ODD_PAR);
        o_frame_err  <= ferr_acc | ~rxs;
        o_break      <= ~(any_one | rxs);
      end
    end
  end

  assign o_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) on separate lines, each frame
// compared against a model built from the bits actually placed on the line.
module tb_uart_rx_cfg;
  localparam int CPB = 16;
  localparam int MID = (CPB - 1) / 2;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] rx = 3'b111;
  logic [2:0] v, pe, fe, br, bz;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  int cyc = 0;
  int pass_cnt = 0, total_cnt = 0;
  int spur = 0;
  int last_t0 = 0;
  int stamp [3];
  logic [2:0] vprev = 3'b000, ba = 3'b000;
  frame_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx[0]), .o_rx_valid(v[0]), .o_rx_data(d0),
    .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_break(br[0]), .o_busy(bz[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx[1]), .o_rx_valid(v[1]), .o_rx_data(d1),
    .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_break(br[1]), .o_busy(bz[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_7o2 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx[2]), .o_rx_valid(v[2]), .o_rx_data(d2),
    .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_break(br[2]), .o_busy(bz[2]));

  // Frame collector; also notes busy one cycle after each pulse and any flag seen without valid.
  always @(negedge clk) begin
    if (v[0]) begin q0.push_back({1'b0, d0, pe[0], fe[0], br[0]}); stamp[0] <= cyc; end
    if (v[1]) begin q1.push_back({1'b0, d1, pe[1], fe[1], br[1]}); stamp[1] <= cyc; end
    if (v[2]) begin q2.push_back({2'b00, d2, pe[2], fe[2], br[2]}); stamp[2] <= cyc; end
    for (int i = 0; i < 3; i++) begin
      if (vprev[i]) ba[i] <= bz[i];
      if (!v[i] && (pe[i] || fe[i] || br[i])) spur <= spur + 1;
    end
    vprev <= v;
  end

  function automatic void cfg(input int inst, output int nb, output int pm, output int ns);
    case (inst)
      0:       begin nb = 8; pm = 0; ns = 1; end
      1:       begin nb = 8; pm = 2; ns = 1; end
      default: begin nb = 7; pm = 1; ns = 2; end
    endcase
  endfunction

  function automatic int qsize(input int inst);
    case (inst)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic frame_t qpop(input int inst);
    case (inst)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic [8:0] mask(input int inst, input logic [8:0] d);
    int nb, pm, ns;
    cfg(inst, nb, pm, ns);
    return d & ((9'd1 << nb) - 9'd1);
  endfunction

  // Parity bit that makes the frame correct for the instance's mode.
  function automatic logic good_par(input int inst, input logic [8:0] d);
    int nb, pm, ns, ones;
    cfg(inst, nb, pm, ns);
    ones = $countones(mask(inst, d));
    return (pm == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  function automatic frame_t model(input int inst, input logic [8:0] d, input logic pbit,
                                   input logic [1:0] stops);
    int nb, pm, ns, ones;
    frame_t f;
    cfg(inst, nb, pm, ns);
    f.data = mask(inst, d);
    ones   = $countones(f.data) + ((pm != 0) ? int'(pbit) : 0);
    f.perr = (pm != 0) && ((ones % 2) != ((pm == 1) ? 1 : 0));
    f.ferr = !stops[0] || (ns == 2 && !stops[1]);
    f.brk  = (f.data == 0) && (pm == 0 || !pbit) && !stops[0] && (ns == 1 || !stops[1]);
    return f;
  endfunction

  // Drives one frame, then two bit times of idle. Jitter inverts the first two cycles of each
  // non-start bit to show that only the mid-bit sample matters.
  task automatic send_frame(input int inst, input logic [8:0] d, input logic pbit,
                            input logic [1:0] stops, input bit jitter);
    int nb, pm, ns;
    logic b[$];
    cfg(inst, nb, pm, ns);
    b.push_back(1'b0);
    for (int i = 0; i < nb; i++) b.push_back(d[i]);
    if (pm != 0) b.push_back(pbit);
    for (int i = 0; i < ns; i++) b.push_back(stops[i]);
    @(negedge clk);
    last_t0 = cyc;
    for (int k = 0; k < b.size(); k++)
      for (int c = 0; c < CPB; c++) begin
        rx[inst] = (jitter && k > 0 && c < 2) ? ~b[k] : b[k];
        @(negedge clk);
      end
    rx[inst] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic wait_frame(input int inst, output frame_t f, output bit got);
    got = 0;
    f   = '0;
    for (int i = 0; i < 50 * CPB && !got; i++) begin
      if (qsize(inst) > 0) begin f = qpop(inst); got = 1; end
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({v[i], pe[i], fe[i], br[i], bz[i]} !== 5'b0 || (i == 0 && d0 !== 0) ||
          (i == 1 && d1 !== 0) || (i == 2 && d2 !== 0))
        $display("FAIL reset inst%0d flags=%b busy=%b expected all zero",
                 i, {v[i], pe[i], fe[i], br[i]}, bz[i]);
      else pass_cnt++;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_8n1;
    frame_t f, e;
    bit got;
    int lat, exp_lat;
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 0);
    wait_frame(0, f, got);
    e = model(0, 9'h0A5, 1'b0, 2'b11);
    total_cnt++;
    if (!got || f !== e || f.data !== 9'h0A5) $display("FAIL 8n1_a5 got=%h (seen=%0d) exp=%h", f, got, e);
    else pass_cnt++;
    total_cnt++;
    if (ba[0] !== 1'b0) $display("FAIL 8n1_busy_after got=%b exp=0", ba[0]);
    else pass_cnt++;
    lat = stamp[0] - last_t0;
    exp_lat = 3 + MID + 9 * CPB;
    total_cnt++;
    if (lat < exp_lat - 1 || lat > exp_lat + 1) $display("FAIL 8n1_latency got=%0d exp=%0d+-1", lat, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (qsize(0) != 0) $display("FAIL 8n1_single_pulse extra=%0d exp=0", qsize(0));
    else pass_cnt++;
  endtask

  task automatic test_8e1;
    frame_t f;
    bit got;
    send_frame(1, 9'h003, 1'b1, 2'b11, 0);
    wait_frame(1, f, got);
    total_cnt++;
    if (!got || f !== {9'h003, 1'b1, 1'b0, 1'b0}) $display("FAIL 8e1_bad_par got=%h (seen=%0d) exp=%h", f, got, {9'h003, 3'b100});
    else pass_cnt++;
    send_frame(1, 9'h003, 1'b0, 2'b11, 0);
    wait_frame(1, f, got);
    total_cnt++;
    if (!got || f !== {9'h003, 1'b0, 1'b0, 1'b0}) $display("FAIL 8e1_good_par got=%h (seen=%0d) exp=%h", f, got, {9'h003, 3'b000});
    else pass_cnt++;
  endtask

  task automatic test_7o2;
    frame_t f;
    bit got;
    send_frame(2, 9'h055, 1'b1, 2'b01, 0);
    wait_frame(2, f, got);
    total_cnt++;
    if (!got || f !== {9'h055, 1'b0, 1'b1, 1'b0}) $display("FAIL 7o2_stop2_low got=%h (seen=%0d) exp=%h", f, got, {9'h055, 3'b010});
    else pass_cnt++;
    total_cnt++;
    if (ba[2] !== 1'b1) $display("FAIL 7o2_wait_high busy_after got=%b exp=1", ba[2]);
    else pass_cnt++;
  endtask

  task automatic test_break;
    frame_t f;
    bit got;
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (3 * 10 * CPB) @(negedge clk);
    total_cnt++;
    if (bz[0] !== 1'b1 || qsize(0) != 1) $display("FAIL break_low busy=%b pulses=%0d exp busy=1 pulses=1", bz[0], qsize(0));
    else pass_cnt++;
    rx[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    total_cnt++;
    if (bz[0] !== 1'b0 || qsize(0) != 1) $display("FAIL break_release busy=%b pulses=%0d exp busy=0 pulses=1", bz[0], qsize(0));
    else pass_cnt++;
    wait_frame(0, f, got);
    total_cnt++;
    if (!got || f !== {9'h000, 1'b0, 1'b1, 1'b1}) $display("FAIL break_frame got=%h exp=%h", f, {9'h000, 3'b011});
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    frame_t f;
    bit got;
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (6) @(negedge clk);
    rx[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total_cnt++;
    if (qsize(0) != 0 || bz[0] !== 1'b0) $display("FAIL glitch pulses=%0d busy=%b exp 0/0", qsize(0), bz[0]);
    else pass_cnt++;
    send_frame(0, 9'h03C, 1'b0, 2'b11, 0);
    wait_frame(0, f, got);
    total_cnt++;
    if (!got || f !== {9'h03C, 3'b000}) $display("FAIL glitch_then_3c got=%h exp=%h", f, {9'h03C, 3'b000});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    frame_t f;
    bit got;
    logic [7:0] d = 8'h81;
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx[0] = d[k];
      repeat (CPB) @(negedge clk);
    end
    rx[0] = d[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    total_cnt++;
    if (qsize(0) != 0 || bz[0] !== 1'b0) $display("FAIL reset_mid_discard pulses=%0d busy=%b exp 0/0", qsize(0), bz[0]);
    else pass_cnt++;
    send_frame(0, 9'h07E, 1'b0, 2'b11, 0);
    wait_frame(0, f, got);
    total_cnt++;
    if (!got || f !== {9'h07E, 3'b000}) $display("FAIL reset_mid_7e got=%h exp=%h", f, {9'h07E, 3'b000});
    else pass_cnt++;
  endtask

  task automatic test_random;
    frame_t f, e;
    bit got;
    logic [8:0] d;
    logic pbit;
    logic [1:0] stops;
    bit jit;
    for (int inst = 0; inst < 3; inst++)
      for (int n = 0; n < 12; n++) begin
        d     = 9'($urandom);
        pbit  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : good_par(inst, d);
        stops = {1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 5) != 0)};
        if (n == 0) begin d = '0; pbit = 1'b0; stops = 2'b00; end
        jit   = 1'($urandom);
        e = model(inst, d, pbit, stops);
        send_frame(inst, d, pbit, stops, jit);
        wait_frame(inst, f, got);
        total_cnt++;
        if (!got || f !== e || qsize(inst) != 0)
          $display("FAIL random inst%0d n=%0d got=%h exp=%h seen=%0d extra=%0d", inst, n, f, e, got, qsize(inst));
        else pass_cnt++;
      end
  endtask

  task automatic test_flag_pulses;
    total_cnt++;
    if (spur != 0) $display("FAIL flag_outside_valid count=%0d exp=0", spur);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_8e1;
    test_7o2;
    test_break;
    test_glitch;
    test_reset_mid;
    test_random;
    test_flag_pulses;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
